// File: rtl/braille_round_ctrl.sv
// -----------------------------------------------------------------------------
// braille_round_ctrl
//   Round sequencer for the Braille trainer. Each session runs NUM_ROUNDS
//   rounds. A round fetches a target cell from an external registered ROM,
//   arms the 9-step countdown timer, and waits for either a key entry or
//   the timer's stop flag. It then scores the answer, holds for RESULT_HOLD
//   cycles, and advances to the next round.
//
//   Optional build macro:
//     BRAILLE_RETRY_EN - the first wrong entry of a round pulses `wrong` and
//                        keeps waiting on the same timer run. A second wrong
//                        entry, a correct entry, or a timeout ends the round.
//                        Without the macro, any wrong entry ends the round.
//
//   Reset is synchronous and active-low on `rst`. Every output is a register.
// -----------------------------------------------------------------------------
module braille_round_ctrl #(
   parameter int TICK_DIV    = 50000000, // clk cycles per timer decrement, >= 2
   parameter int NUM_ROUNDS  = 10,       // rounds per session, 1..2**ADDR_W
   parameter int ADDR_W      = 5,        // target ROM address width
   parameter int SCORE_W     = 4,        // score counter width
   parameter int RESULT_HOLD = 4         // idle cycles after a result, >= 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              key_valid,
   input  logic [5:0]        key_pat,
   output logic [ADDR_W-1:0] tgt_addr,
   input  logic [5:0]        tgt_pat,
   output logic              timer_rst,
   output logic              timer_dec,
   input  logic              timer_stop,
   output logic              correct,
   output logic              wrong,
   output logic              timeout,
   output logic [SCORE_W-1:0] score,
   output logic [ADDR_W-1:0] round,
   output logic              busy,
   output logic              done
);

   localparam int PS_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD + 1) : 1;

   localparam logic [PS_W-1:0]    PS_LAST    = PS_W'(TICK_DIV - 1);
   // The decrement strobe is registered. It is scheduled one count early so
   // that it is high exactly while the prescaler holds TICK_DIV-1.
   localparam logic [PS_W-1:0]    PS_PRE     = PS_W'(TICK_DIV - 2);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESULT_HOLD - 1);
   localparam logic [ADDR_W-1:0]  ROUND_LAST = ADDR_W'(NUM_ROUNDS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_WAIT,
      S_RESULT,
      S_DONE
   } state_t;

   state_t             state;
   logic [5:0]         target;
   logic [PS_W-1:0]    prescaler;
   logic [HOLD_W-1:0]  hold_cnt;

   logic key_hit;     // entry matches the latched target
   logic take_retry;  // wrong entry that is forgiven once in this round
   logic leave_wait;  // WAIT resolves this cycle

   assign key_hit = (key_pat == target);

`ifdef BRAILLE_RETRY_EN
   logic retry;       // a wrong entry has already been forgiven this round
   assign take_retry = key_valid && !key_hit && !retry;
`else
   assign take_retry = 1'b0;
`endif

   // A key entry takes priority over the stop flag that arrives in the same cycle.
   assign leave_wait = key_valid ? !take_retry : timer_stop;

   // Session sequencer: state, datapath registers and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: every register, including datapath ones, is cleared so a
         // mid-session reset leaves no stale target or count behind.
         state     <= S_IDLE;
         target    <= '0;
         prescaler <= '0;
         hold_cnt  <= '0;
         tgt_addr  <= '0;
         round     <= '0;
         score     <= '0;
         timer_rst <= 1'b0;
         timer_dec <= 1'b0;
         correct   <= 1'b0;
         wrong     <= 1'b0;
         timeout   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef BRAILLE_RETRY_EN
         retry     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout. A later assignment in
         // the same branch overrides these one-cycle pulse defaults.
         correct   <= 1'b0;
         wrong     <= 1'b0;
         timeout   <= 1'b0;
         timer_dec <= 1'b0;

         case (state)
            S_IDLE, S_DONE: begin
               timer_rst <= 1'b0;
               busy      <= 1'b0;
               done      <= (state == S_DONE);
               if (start) begin
                  state     <= S_LOAD;
                  score     <= '0;
                  round     <= '0;
                  tgt_addr  <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  timer_rst <= 1'b1;
               end
            end

            // The ROM output for the new address is valid during this cycle.
            S_LOAD: begin
               target    <= tgt_pat;
               timer_rst <= 1'b0;
               prescaler <= '0;
               state     <= S_ARM;
`ifdef BRAILLE_RETRY_EN
               retry     <= 1'b0;
`endif
            end

            // The timer is cleared during this single cycle and reloads to 9.
            S_ARM: begin
               timer_rst <= 1'b1;
               prescaler <= '0;
               state     <= S_WAIT;
            end

            S_WAIT: begin
               timer_rst <= 1'b1;
               prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;

               if (key_valid) begin
                  if (key_hit) begin
                     correct <= 1'b1;
                     if (score != SCORE_MAX) begin
                        score <= score + 1'b1;
                     end
                  end else begin
                     wrong <= 1'b1;
                  end
`ifdef BRAILLE_RETRY_EN
                  if (take_retry) begin
                     retry <= 1'b1;
                  end
`endif
               end else if (timer_stop) begin
                  timeout <= 1'b1;
               end

               if (leave_wait) begin
                  state    <= S_RESULT;
                  hold_cnt <= '0;
               end else if (!timer_stop && prescaler == PS_PRE) begin
                  // No decrement once the timer has expired or the round is
                  // ending. The timer would otherwise wrap below zero.
                  timer_dec <= 1'b1;
               end
            end

            S_RESULT: begin
               timer_rst <= 1'b1;
               if (hold_cnt == HOLD_LAST) begin
                  if (round == ROUND_LAST) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     timer_rst <= 1'b0;
                  end else begin
                     state    <= S_LOAD;
                     round    <= round + 1'b1;
                     tgt_addr <= tgt_addr + 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            default: begin
               state     <= S_IDLE;
               timer_rst <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_braille_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_braille_round_ctrl
//   Directed bench for braille_round_ctrl with TICK_DIV=4, NUM_ROUNDS=3 and
//   RESULT_HOLD=2. It models the external ROM and the 9-step countdown timer.
//   Stimulus pushes each expected result pulse (kind and score) into a queue.
//   A negedge monitor pops and compares the queue whenever a pulse appears.
//   A second monitor checks every timer decrement for legality.
// -----------------------------------------------------------------------------
module tb_braille_round_ctrl;

   localparam int TICK_DIV    = 4;
   localparam int NUM_ROUNDS  = 3;
   localparam int ADDR_W      = 5;
   localparam int SCORE_W     = 4;
   localparam int RESULT_HOLD = 2;

   localparam logic [2:0] K_CORRECT = 3'b100;
   localparam logic [2:0] K_WRONG   = 3'b010;
   localparam logic [2:0] K_TIMEOUT = 3'b001;

   typedef struct packed {
      logic [2:0]         kind;
      logic [SCORE_W-1:0] score;
      logic               exits;   // the pulse ends the WAIT phase
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               key_valid;
   logic [5:0]         key_pat;
   logic [ADDR_W-1:0]  tgt_addr;
   logic [5:0]         tgt_pat;
   logic               timer_rst;
   logic               timer_dec;
   logic               timer_stop = 1'b0;
   logic               correct;
   logic               wrong;
   logic               timeout;
   logic [SCORE_W-1:0] score;
   logic [ADDR_W-1:0]  round;
   logic               busy;
   logic               done;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   wait_entry  = 0;
   int   pulse_cnt   = 0;
   int   last_pulse  = 0;
   int   exit_cnt    = 0;
   int   exit_mark   = 0;
   int   arm_cnt     = 0;
   int   tcnt        = 9;
   exp_t exp_q[$];
   int   dec_q[$];

   logic [5:0]  rom [0:3];
   logic [20:0] outs;

   assign tgt_pat = rom[tgt_addr[1:0]];
   assign outs    = {tgt_addr, round, score, timer_rst, timer_dec,
                     correct, wrong, timeout, busy, done};

   braille_round_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .NUM_ROUNDS (NUM_ROUNDS),
      .ADDR_W     (ADDR_W),
      .SCORE_W    (SCORE_W),
      .RESULT_HOLD(RESULT_HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_valid (key_valid),
      .key_pat   (key_pat),
      .tgt_addr  (tgt_addr),
      .tgt_pat   (tgt_pat),
      .timer_rst (timer_rst),
      .timer_dec (timer_dec),
      .timer_stop(timer_stop),
      .correct   (correct),
      .wrong     (wrong),
      .timeout   (timeout),
      .score     (score),
      .round     (round),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Countdown timer model: reloads to 9 while timer_rst is low and raises
   // stop on the decrement that reaches zero.
   always @(posedge clk) begin
      if (!timer_rst) begin
         tcnt       <= 9;
         timer_stop <= 1'b0;
         arm_cnt    <= arm_cnt + 1;
      end else if (timer_dec) begin
         tcnt <= tcnt - 1;
         if (tcnt == 1) timer_stop <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result monitor: compares each result pulse against the head of the queue.
   always @(negedge clk) begin
      if (correct || wrong || timeout) begin
         pulse_cnt++;
         last_pulse = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {correct, wrong, timeout}, 3'b000);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_kind", {correct, wrong, timeout}, e.kind);
            check("result_score", score, e.score);
            if (e.exits) exit_cnt++;
         end
      end
   end

   // Decrement monitor: a decrement is legal only inside WAIT and before stop.
   always @(negedge clk) begin
      if (timer_dec) begin
         dec_q.push_back(cyc - wait_entry);
         check("dec_legal", {timer_stop, (exit_cnt == exit_mark)}, 2'b01);
      end
   end

   task automatic expect_res(input logic [2:0] kind, input int sc, input logic exits);
      exp_t e;
      e.kind  = kind;
      e.score = SCORE_W'(sc);
      e.exits = exits;
      exp_q.push_back(e);
   endtask

   // Returns at the negedge of the first WAIT cycle, once the one-cycle ARM is seen.
   task automatic wait_arm();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(busy && !timer_rst) && n < 100);
      check("arm_seen", {busy, timer_rst}, 2'b10);
      @(negedge clk);
      check("arm_one_cycle", timer_rst, 1'b1);
      wait_entry = cyc;
      exit_mark  = exit_cnt;
      dec_q.delete();
   endtask

   // Drives a one-cycle key strobe d cycles after the current point.
   task automatic drive_key(input logic [5:0] pat, input int d);
      repeat (d) begin
         @(posedge clk);
         #1;
      end
      key_valid = 1'b1;
      key_pat   = pat;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   task automatic wait_pulse(input int target);
      int n = 0;
      while (pulse_cnt < target && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("pulse_arrived", (pulse_cnt >= target), 1'b1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got no summary, expected summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int n;
      int arm0;
      int delays [0:2];

      rom[0] = 6'b000001;
      rom[1] = 6'b010110;
      rom[2] = 6'b101101;
      rom[3] = 6'b111000;
      delays[0] = 1;
      delays[1] = 6;
      delays[2] = 10;

      rst       = 1'b0;
      start     = 1'b0;
      key_valid = 1'b0;
      key_pat   = 6'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", outs, 21'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // ---- Session 1 ---------------------------------------------------
      pulse_start();

      // Round 0: correct key 5 cycles into WAIT.
      wait_arm();
      expect_res(K_CORRECT, 1, 1'b1);
      drive_key(rom[0], 5);
      @(negedge clk);
      check("addr_result0", tgt_addr, 0);
      @(negedge clk);
      check("addr_result1", tgt_addr, 0);
      @(negedge clk);
      check("addr_next", tgt_addr, 1);
      check("round_next", round, 1);

      // Round 1: no key, so the timer runs out.
      wait_arm();
      expect_res(K_TIMEOUT, 1, 1'b1);
      wait_pulse(pulse_cnt + 1);
      check("dec_count", dec_q.size(), 9);
      check("dec_first", (dec_q.size() > 0) ? dec_q[0] : -1, TICK_DIV - 1);
      bad = 0;
      for (int i = 1; i < dec_q.size(); i++)
         if (dec_q[i] - dec_q[i-1] != TICK_DIV) bad++;
      check("dec_spacing", bad, 0);
      check("timeout_cycle", last_pulse - wait_entry, 9 * TICK_DIV + 1);

      // Round 2: matching key in the same cycle stop is first seen.
      wait_arm();
      n = 0;
      while (!timer_stop && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("stop_cycle", cyc - wait_entry, 9 * TICK_DIV);
      expect_res(K_CORRECT, 2, 1'b1);
      drive_key(rom[2], 0);
      wait_done();
      check("session1_done", {done, busy, timer_rst, score, round}, {3'b100, 4'd2, 5'd2});

      // ---- Session 2: three correct rounds -----------------------------
      pulse_start();
      @(negedge clk);
      check("restart_load", {done, busy, score, round, tgt_addr}, {2'b01, 4'd0, 5'd0, 5'd0});
      for (int i = 0; i < 3; i++) begin
         wait_arm();
         expect_res(K_CORRECT, i + 1, 1'b1);
         drive_key(rom[i], delays[i]);
      end
      wait_done();
      check("session2_done", {done, busy, timer_rst, score, round}, {3'b100, 4'd3, 5'd2});
      pulse_start();
      @(negedge clk);
      check("restart2_load", {done, busy, score, round, tgt_addr}, {2'b01, 4'd0, 5'd0, 5'd0});

      // ---- Session 3: wrong entry handling, then reset mid-WAIT -------
      wait_arm();
      arm0 = arm_cnt;
`ifdef BRAILLE_RETRY_EN
      expect_res(K_WRONG, 0, 1'b0);
      drive_key(6'b111111, 4);
      expect_res(K_CORRECT, 1, 1'b1);
      drive_key(rom[0], 3);
      wait_pulse(pulse_cnt + 1);
      check("no_rearm_on_retry", arm_cnt, arm0);
`else
      expect_res(K_WRONG, 0, 1'b1);
      drive_key(6'b111111, 4);
      wait_pulse(pulse_cnt + 1);
      check("wrong_no_rearm_yet", arm_cnt, arm0);
`endif
      wait_arm();
      check("round_after_first", round, 1);

      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_mid_wait", outs, 21'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_after_reset", {busy, done, timer_rst}, 3'b000);
      check("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
